// File: rtl/ram_port_arbiter.sv
// Two-master Avalon-MM arbiter sharing one single-port on-chip RAM, with a hold/drain quiesce handshake.
// Build option: define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise m0 has fixed priority.
module ram_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata,
    input  logic              hold,
    output logic              hold_ack
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    state_t state_q;
    logic   rd_vld_q;
    logic   rd_own_q;
    logic   clken_q;
    logic   req0_s, req1_s, allow_s, pick1_s;
    logic   grant0_s, grant1_s, rd_grant_s;

    assign req0_s  = m0_read | m0_write;
    assign req1_s  = m1_read | m1_write;
    // clken_q doubles as "out of reset" so no grant is visible while reset is active
    assign allow_s = clken_q & (state_q == ST_RUN) & ~hold;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic last_q;

    assign pick1_s = ~last_q;

    // Remember the winner of the most recent accepted transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (grant0_s | grant1_s) begin
            last_q <= grant1_s;
        end else begin
            last_q <= last_q;
        end
    end
`else
    assign pick1_s = 1'b0;
`endif

    // Same-cycle grant decision
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (allow_s) begin
            if (req0_s && req1_s) begin
                grant1_s = pick1_s;
                grant0_s = ~pick1_s;
            end else begin
                grant0_s = req0_s;
                grant1_s = req1_s;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Command mux onto the RAM bus; port 0 is the idle default
    always_comb begin
        ram_address    = m0_address;
        ram_byteenable = m0_byteenable;
        ram_writedata  = m0_writedata;
        ram_write      = 1'b0;
        if (grant1_s) begin
            ram_address    = m1_address;
            ram_writedata  = m1_writedata;
            ram_write      = m1_write;
            ram_byteenable = m1_write ? m1_byteenable : {BE_W{1'b1}};
        end else if (grant0_s) begin
            ram_write      = m0_write;
            ram_byteenable = m0_write ? m0_byteenable : {BE_W{1'b1}};
        end else begin
            ram_write      = 1'b0;
        end
    end

    // A write wins over a simultaneous read, so only pure reads expect data back
    assign rd_grant_s = (grant0_s & ~m0_write) | (grant1_s & ~m1_write);

    // Read tracking, clock enable and quiesce FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_RUN;
            rd_vld_q <= 1'b0;
            rd_own_q <= 1'b0;
            clken_q  <= 1'b0;
        end else begin
            rd_vld_q <= rd_grant_s;
            rd_own_q <= grant1_s;
            clken_q  <= 1'b1;
            case (state_q)
                ST_RUN: begin
                    if (hold) begin
                        state_q <= rd_vld_q ? ST_DRAIN : ST_HELD;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DRAIN: state_q <= hold ? ST_HELD : ST_RUN;
                ST_HELD:  state_q <= hold ? ST_HELD : ST_RUN;
                default:  state_q <= ST_RUN;
            endcase
        end
    end

    assign m0_waitrequest   = ~grant0_s;
    assign m1_waitrequest   = ~grant1_s;
    assign ram_chipselect   = grant0_s | grant1_s;
    assign ram_clken        = clken_q;
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign m0_readdatavalid = rd_vld_q & ~rd_own_q;
    assign m1_readdatavalid = rd_vld_q & rd_own_q;
    assign hold_ack         = (state_q == ST_HELD);

endmodule
